// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader and its SRAM steering.
package boot_pkg;

  localparam int BANK_WORDS = 16384;
  localparam int MEM_WORDS  = 2 * BANK_WORDS;
  localparam int AW         = $clog2(BANK_WORDS);
  localparam int IW         = $clog2(MEM_WORDS);

  localparam logic [IW-1:0] CNT_MAX = IW'(MEM_WORDS - 1);

  localparam logic [3:0] WEB_WR = 4'h0;
  localparam logic [3:0] WEB_RD = 4'hF;

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, DONE, FAIL} boot_state_e;

  typedef struct packed {
    logic          cs;
    logic          oe;
    logic [3:0]    web;
    logic [AW-1:0] a;
    logic [31:0]   di;
  } sram_req_t;

  localparam sram_req_t REQ_IDLE = '{cs: 1'b0, oe: 1'b0, web: WEB_RD, a: '0, di: '0};

  function automatic sram_req_t req_write(input logic [AW-1:0] a, input logic [31:0] d);
    return '{cs: 1'b1, oe: 1'b0, web: WEB_WR, a: a, di: d};
  endfunction

  function automatic sram_req_t req_read(input logic [AW-1:0] a);
    return '{cs: 1'b1, oe: 1'b1, web: WEB_RD, a: a, di: '0};
  endfunction

endpackage

// File: rtl/boot_sram_mux.sv
// Steers a single SRAM request to IM or DM and returns read data from the
// bank that was addressed on the previous cycle.
module boot_sram_mux
  import boot_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  sram_req_t     req,
  input  logic          bank,
  output logic          im_cs,
  output logic          im_oe,
  output logic [3:0]    im_web,
  output logic [AW-1:0] im_a,
  output logic [31:0]   im_di,
  input  logic [31:0]   im_do,
  output logic          dm_cs,
  output logic          dm_oe,
  output logic [3:0]    dm_web,
  output logic [AW-1:0] dm_a,
  output logic [31:0]   dm_di,
  input  logic [31:0]   dm_do,
  output logic [31:0]   rdata
);

  logic      bank_d;
  sram_req_t im_req;
  sram_req_t dm_req;

  // Remember which bank was read so the returning data is taken from it.
  always_ff @(posedge clk) begin
    if (!rst) bank_d <= 1'b0;
    else      bank_d <= bank;
  end

  // The unselected bank is held idle so it never sees a stray write.
  always_comb begin
    im_req = bank ? REQ_IDLE : req;
    dm_req = bank ? req : REQ_IDLE;
  end

  assign im_cs  = im_req.cs;
  assign im_oe  = im_req.oe;
  assign im_web = im_req.web;
  assign im_a   = im_req.a;
  assign im_di  = im_req.di;
  assign dm_cs  = dm_req.cs;
  assign dm_oe  = dm_req.oe;
  assign dm_web = dm_req.web;
  assign dm_a   = dm_req.a;
  assign dm_di  = dm_req.di;
  assign rdata  = bank_d ? dm_do : im_do;

endmodule

// File: rtl/boot_loader.sv
// Loads a word stream into IM then DM, reads it all back, and releases the
// CPU only if the read-back sum equals the sum of the words written.
//
// Stream handshake: a word moves when s_valid and s_ready are both 1 at a
// rising edge. s_ready is registered, 1 only while loading, and drops the
// cycle after the final accepted word; s_data/s_last are ignored otherwise.
module boot_loader
  import boot_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_data,
  input  logic          s_last,
  output logic          im_cs,
  output logic          im_oe,
  output logic [3:0]    im_web,
  output logic [AW-1:0] im_a,
  output logic [31:0]   im_di,
  input  logic [31:0]   im_do,
  output logic          dm_cs,
  output logic          dm_oe,
  output logic [3:0]    dm_web,
  output logic [AW-1:0] dm_a,
  output logic [31:0]   dm_di,
  input  logic [31:0]   dm_do,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [2:0]    state
);

  boot_state_e   state_q;
  sram_req_t     req;
  logic          bank;
  logic [IW-1:0] cnt;
  logic [IW:0]   total;
  logic [IW:0]   rcnt;
  logic [31:0]   wsum;
  logic [31:0]   rsum;
  logic [31:0]   rdata;
  logic          rd_v1, rd_v2;
  logic          rd_last1, rd_last2;

  assign state = state_q;

  // Main controller: load, then a two-stage read pipeline feeding the sum check.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      req      <= REQ_IDLE;
      bank     <= 1'b0;
      cnt      <= '0;
      total    <= '0;
      rcnt     <= '0;
      wsum     <= '0;
      rsum     <= '0;
      rd_v1    <= 1'b0;
      rd_v2    <= 1'b0;
      rd_last1 <= 1'b0;
      rd_last2 <= 1'b0;
      s_ready  <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      // SRAM requests are single-cycle pulses unless re-issued below.
      req      <= REQ_IDLE;
      bank     <= 1'b0;
      rd_v1    <= 1'b0;
      rd_last1 <= 1'b0;
      rd_v2    <= rd_v1;
      rd_last2 <= rd_last1;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            s_ready <= 1'b1;
            cnt     <= '0;
            wsum    <= '0;
          end
        end
        LOAD: begin
          if (s_valid && s_ready) begin
            req  <= req_write(cnt[AW-1:0], s_data);
            bank <= cnt[AW];
            wsum <= wsum + s_data;
            cnt  <= cnt + 1'b1;
            // A full image ends the load even without s_last, so cnt never wraps.
            if (s_last || cnt == CNT_MAX) begin
              state_q <= VERIFY;
              s_ready <= 1'b0;
              total   <= {1'b0, cnt} + 1'b1;
              rcnt    <= '0;
              rsum    <= '0;
            end
          end
        end
        VERIFY: begin
          if (rcnt != total) begin
            req      <= req_read(rcnt[AW-1:0]);
            bank     <= rcnt[AW];
            rcnt     <= rcnt + 1'b1;
            rd_v1    <= 1'b1;
            rd_last1 <= (rcnt == total - 1'b1);
          end
          if (rd_v2) begin
            rsum <= rsum + rdata;
            if (rd_last2) begin
              if (rsum + rdata == wsum) begin
                state_q  <= DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                state_q  <= FAIL;
                error    <= 1'b1;
                cpu_hold <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
        FAIL: begin
          error    <= 1'b1;
          cpu_hold <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  boot_sram_mux u_mux (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .bank   (bank),
    .im_cs  (im_cs),
    .im_oe  (im_oe),
    .im_web (im_web),
    .im_a   (im_a),
    .im_di  (im_di),
    .im_do  (im_do),
    .dm_cs  (dm_cs),
    .dm_oe  (dm_oe),
    .dm_web (dm_web),
    .dm_a   (dm_a),
    .dm_di  (dm_di),
    .dm_do  (dm_do),
    .rdata  (rdata)
  );

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader with behavioural IM/DM SRAMs and a write scoreboard.
module tb_boot_loader;

  localparam int BANK = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        im_cs, im_oe, dm_cs, dm_oe;
  logic [3:0]  im_web, dm_web;
  logic [13:0] im_a, dm_a;
  logic [31:0] im_di, dm_di;
  logic [31:0] im_do, dm_do;
  logic        cpu_hold, done, error;
  logic [2:0]  dbg_state;

  logic [31:0] im_mem [0:BANK-1];
  logic [31:0] dm_mem [0:BANK-1];
  logic        corrupt_dm0 = 1'b0;

  logic [46:0] exp_q[$];
  logic [46:0] wr_log[$];
  int          wr_rd = 0;
  int          vectors = 0;
  int          miscompares = 0;

  boot_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .im_cs    (im_cs),
    .im_oe    (im_oe),
    .im_web   (im_web),
    .im_a     (im_a),
    .im_di    (im_di),
    .im_do    (im_do),
    .dm_cs    (dm_cs),
    .dm_oe    (dm_oe),
    .dm_web   (dm_web),
    .dm_a     (dm_a),
    .dm_di    (dm_di),
    .dm_do    (dm_do),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error),
    .state    (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // SRAM models: write on web==0, registered read, every write attempt logged
  always @(posedge clk) begin
    if (im_cs && im_web != 4'hF) begin
      if (im_web == 4'h0) im_mem[im_a] <= im_di;
      wr_log.push_back({1'b0, im_a, im_di});
    end
    if (im_cs && im_oe) im_do <= im_mem[im_a];
    if (dm_cs && dm_web != 4'hF) begin
      if (dm_web == 4'h0) dm_mem[dm_a] <= dm_di;
      wr_log.push_back({1'b1, dm_a, dm_di});
    end
    if (dm_cs && dm_oe)
      dm_do <= dm_mem[dm_a] ^ ((corrupt_dm0 && dm_a == 14'd0) ? 32'h0000_0100 : 32'h0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, output bit ok);
    int  waits;
    bit  rdy;
    waits = 0;
    ok = 1'b0;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = d; s_last = last;
    forever begin
      rdy = s_ready;
      @(posedge clk);
      if (rdy) begin ok = 1'b1; break; end
      waits++;
      if (waits > 20) break;
      @(negedge clk);
    end
  endtask

  // mode: 0 = 0x11111111*(k+1), 1 = k, 2 = 0xDEADBEEF, 3 = random
  task automatic run_load(input int n, input int mode, input bit gaps,
                          input bit corrupt, input bit exp_ok);
    logic [31:0] d;
    logic [14:0] kk;
    logic [46:0] e, got;
    bit          ok, seen;
    int          lat;
    // start pulse with a junk final word that must not be taken
    @(negedge clk);
    start = 1'b1; s_valid = 1'b1; s_data = 32'hBAD0_BAD0; s_last = 1'b1;
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0) begin
        @(negedge clk);
        start = 1'b0; s_valid = 1'b0; s_data = $urandom; s_last = 1'b1;
        @(posedge clk);
      end
      case (mode)
        0:       d = 32'(k + 1) * 32'h1111_1111;
        1:       d = 32'(k);
        2:       d = 32'hDEAD_BEEF;
        default: d = $urandom;
      endcase
      send_word(d, k == n - 1, ok);
      check("accept", ok, 1);
      if (!ok) break;
      kk = 15'(k);
      exp_q.push_back({kk[14], kk[13:0], d});
    end
    if (corrupt) corrupt_dm0 = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < n + 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      s_valid = 1'b0; start = 1'b0; s_last = 1'b0;
      if (done || error) begin seen = 1'b1; break; end
    end
    check("finish_seen", seen, 1);
    check("verify_latency", lat, n + 2);
    check("done", done, exp_ok);
    check("error", error, !exp_ok);
    check("cpu_hold", cpu_hold, !exp_ok);
    check("s_ready_low", s_ready, 0);
    check("sram_idle", {im_cs, im_oe, dm_cs, dm_oe, im_web, dm_web}, {4'b0000, 8'hFF});
    corrupt_dm0 = 1'b0;
    check("write_count", wr_log.size() - wr_rd, exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (wr_rd < wr_log.size()) ? wr_log[wr_rd] : 'x;
      wr_rd++;
      check("write", got, e);
    end
    wr_rd = wr_log.size();
  endtask

  initial begin
    int snap;
    // 1: reset with start held high
    rst = 1'b0; start = 1'b1; s_valid = 1'b1; s_data = 32'h1234_5678; s_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_webs", {im_web, dm_web}, 8'hFF);
    check("rst_cs_oe", {im_cs, im_oe, dm_cs, dm_oe}, 4'b0000);
    check("rst_done_err", {done, error}, 2'b00);
    check("rst_state", dbg_state, 3'd0);
    start = 1'b0; s_valid = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_ready", s_ready, 0);
    check("idle_no_write", wr_log.size(), 0);

    // 2: four-word image
    run_load(4, 0, 1'b0, 1'b0, 1'b1);
    check("im0", im_mem[0], 32'h1111_1111);
    check("im1", im_mem[1], 32'h2222_2222);
    check("im2", im_mem[2], 32'h3333_3333);
    check("im3", im_mem[3], 32'h4444_4444);
    // start in DONE is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("done_sticky", {done, cpu_hold, s_ready}, 3'b100);

    // 3: image crossing the IM/DM boundary
    do_reset();
    run_load(16386, 1, 1'b0, 1'b0, 1'b1);
    check("im16383", im_mem[16383], 32'd16383);
    check("dm0", dm_mem[0], 32'd16384);
    check("dm1", dm_mem[1], 32'd16385);

    // 4: same image with DM[0] corrupted during verify
    do_reset();
    run_load(16386, 1, 1'b0, 1'b1, 1'b0);

    // 5: valid toggling every cycle, random data
    do_reset();
    run_load(8, 3, 1'b1, 1'b0, 1'b1);

    // 6: reset mid-load with a word pending, then a one-word image
    do_reset();
    snap = wr_log.size();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_in_load", s_ready, 1);
    s_valid = 1'b1; s_data = 32'hCAFE_F00D; s_last = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("abort_rst_ready", s_ready, 0);
    check("abort_rst_web", {im_cs, im_web}, 5'h0F);
    s_valid = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_write", wr_log.size(), snap);
    wr_rd = wr_log.size();
    run_load(1, 2, 1'b0, 1'b0, 1'b1);
    check("im0_beef", im_mem[0], 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
